// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
//   rx_state_t  deframing FSM state encoding
//   OVERSAMPLE  ticks per bit period
//   DATA_BITS   data bits per character (8N1)
//   MID_TICK    tick index of the start-bit centre
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int MID_TICK   = 7;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word fall-through FIFO.
//   clk, rst_n  clock, asynchronous active-low reset
//   push, wdata write request and data (ignored when full unless popping)
//   pop         read request (ignored when empty)
//   rdata       head entry, valid whenever empty is low
//   level       number of stored entries, 0..DEPTH
//   full, empty status
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [AW:0]      wr_cnt;
  logic [AW:0]      rd_cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign level   = wr_cnt - rd_cnt;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  // When full, a same-cycle pop frees the slot being written.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_cnt[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_cnt[AW-1:0]] <= wdata;
        wr_cnt              <= wr_cnt + 1'b1;
      end
      if (do_pop) rd_cnt <= rd_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 RS232 receiver with 16x oversampling and a receive FIFO.
//   Clk, Rst_n   system clock, asynchronous active-low reset
//   Rx           serial input, idle high, asynchronous to Clk
//   Rx_data      head-of-FIFO byte (first-word fall-through)
//   Rx_valid     FIFO not empty
//   Rx_ready     consumer takes Rx_data this cycle
//   Rx_level     bytes stored
//   Frame_err    sticky, stop bit sampled low
//   Overrun_err  sticky, byte completed while FIFO full
//   Err_clr      pulse clearing both sticky flags (a same-cycle set wins)
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge
// START | counting to the start-bit centre, rejecting glitches
// DATA  | sampling 8 data bits LSB first, one per 16 ticks
// STOP  | sampling the stop bit, then push or flag frame error
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic                          Rx,
  output logic [7:0]                    Rx_data,
  output logic                          Rx_valid,
  input  logic                          Rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   Rx_level,
  output logic                          Frame_err,
  output logic                          Overrun_err,
  input  logic                          Err_clr
);

  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = $clog2(DIV + 1);

  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;
  logic             rx_fall;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  rx_state_t        state;
  logic [3:0]       tick_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic             push_req;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;

  // Two-flop synchroniser plus one history flop for edge detection.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= Rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev && !rx_sync;

  // Oversampling tick: down-counter reloaded on terminal count, and reloaded
  // on the start edge so the mid-bit samples line up with this frame.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      div_cnt <= DIV_W'(DIV - 1);
    end else if ((state == IDLE && rx_fall) || div_cnt == '0) begin
      div_cnt <= DIV_W'(DIV - 1);
    end else begin
      div_cnt <= div_cnt - 1'b1;
    end
  end

  assign tick = (div_cnt == '0);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      push_req  <= 1'b0;
      Frame_err <= 1'b0;
    end else begin
      push_req <= 1'b0;
      if (Err_clr) Frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          // Only an edge starts a frame, so a held-low break cannot retrigger.
          if (rx_fall) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (tick_cnt == 4'(MID_TICK)) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= rx_sync ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tick_cnt == 4'(OVERSAMPLE - 1)) begin
              tick_cnt  <= '0;
              shift_reg <= {rx_sync, shift_reg[7:1]};
              if (bit_cnt == 3'(DATA_BITS - 1)) state <= STOP;
              else bit_cnt <= bit_cnt + 1'b1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (tick_cnt == 4'(OVERSAMPLE - 1)) begin
              tick_cnt <= '0;
              state    <= IDLE;
              if (rx_sync) push_req  <= 1'b1;
              else         Frame_err <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pop = Rx_valid && Rx_ready;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Overrun_err <= 1'b0;
    end else if (push_req && fifo_full && !pop) begin
      Overrun_err <= 1'b1;
    end else if (Err_clr) begin
      Overrun_err <= 1'b0;
    end
  end

  // shift_reg is stable while push_req is high: it only shifts in DATA.
  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (Clk),
    .rst_n (Rst_n),
    .push  (push_req),
    .wdata (shift_reg),
    .pop   (pop),
    .rdata (Rx_data),
    .level (Rx_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign Rx_valid = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo. Runs at 460800 baud on a 50 MHz clock to keep the
// run short: DIV truncates 6.78 -> 6, so one bit is 16*6 clocks = 1920 ns.
// The idle-line glitch is scaled to stay well under half a bit.
module tb_uart_rx_fifo;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 460800;
  localparam int DEPTH    = 16;
  localparam int DIV      = CLK_FREQ / (BAUD * 16);
  localparam int BIT_NS   = 20 * 16 * DIV;
  localparam int GLITCH_NS = 500;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       Rx = 1'b1;
  logic       Rx_ready = 1'b0;
  logic       Err_clr = 1'b0;
  logic [7:0] Rx_data;
  logic       Rx_valid;
  logic [4:0] Rx_level;
  logic       Frame_err;
  logic       Overrun_err;

  uart_rx_fifo #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .Rx          (Rx),
    .Rx_data     (Rx_data),
    .Rx_valid    (Rx_valid),
    .Rx_ready    (Rx_ready),
    .Rx_level    (Rx_level),
    .Frame_err   (Frame_err),
    .Overrun_err (Overrun_err),
    .Err_clr     (Err_clr)
  );

  always #10 Clk = ~Clk;

  int         checks = 0;
  int         errors = 0;
  int         pops = 0;
  int         max_lvl = 0;
  logic       track = 1'b0;
  logic [7:0] q[$];

  typedef struct {
    logic [7:0] data;
    bit         stop;
    int         exp_level;
    bit         exp_fe;
    bit         drain;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted pop must match the oldest expected byte.
  always @(negedge Clk) begin
    if (track && int'(Rx_level) > max_lvl) max_lvl = int'(Rx_level);
    if (Rst_n && Rx_valid && Rx_ready) begin
      pops++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected actual=%0h required=none", Rx_data);
      end else begin
        chk("pop_data", 32'(Rx_data), 32'(q.pop_front()));
      end
    end
  end

  task automatic send_frame(input logic [7:0] d, input bit stop);
    Rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      Rx = d[i];
      #(BIT_NS);
    end
    Rx = stop;
    #(BIT_NS);
    Rx = 1'b1;
  endtask

  task automatic drain(input string name);
    @(posedge Clk) #1 Rx_ready = 1'b1;
    for (int i = 0; i < 200 && Rx_level != 0; i++) @(posedge Clk) #1;
    Rx_ready = 1'b0;
    @(negedge Clk);
    chk({name, "_drain_level"}, 32'(Rx_level), 32'd0);
    chk({name, "_drain_queue"}, 32'(q.size()), 32'd0);
  endtask

  task automatic err_clear();
    @(posedge Clk) #1 Err_clr = 1'b1;
    @(posedge Clk) #1 Err_clr = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    int pops_before;

    vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_level: 1, exp_fe: 1'b0, drain: 1'b1};
    vecs[1] = '{data: 8'h3C, stop: 1'b0, exp_level: 0, exp_fe: 1'b1, drain: 1'b0};
    vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_level: 1, exp_fe: 1'b0, drain: 1'b0};
    vecs[3] = '{data: 8'h00, stop: 1'b1, exp_level: 2, exp_fe: 1'b0, drain: 1'b0};
    vecs[4] = '{data: 8'h81, stop: 1'b0, exp_level: 2, exp_fe: 1'b1, drain: 1'b1};

    repeat (3) @(negedge Clk);
    chk("rst_valid", 32'(Rx_valid), 32'd0);
    chk("rst_level", 32'(Rx_level), 32'd0);
    chk("rst_data", 32'(Rx_data), 32'd0);
    chk("rst_frame_err", 32'(Frame_err), 32'd0);
    chk("rst_overrun", 32'(Overrun_err), 32'd0);
    @(posedge Clk) #1 Rst_n = 1'b1;
    #(BIT_NS);

    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].data, vecs[i].stop);
      if (vecs[i].stop) q.push_back(vecs[i].data);
      repeat (4) @(negedge Clk);
      chk($sformatf("v%0d_level", i), 32'(Rx_level), 32'(vecs[i].exp_level));
      chk($sformatf("v%0d_valid", i), 32'(Rx_valid), 32'(vecs[i].exp_level != 0));
      chk($sformatf("v%0d_frame_err", i), 32'(Frame_err), 32'(vecs[i].exp_fe));
      chk($sformatf("v%0d_overrun", i), 32'(Overrun_err), 32'd0);
      if (vecs[i].exp_level != 0 && q.size() != 0)
        chk($sformatf("v%0d_head", i), 32'(Rx_data), 32'(q[0]));
      if (vecs[i].exp_fe) begin
        err_clear();
        chk($sformatf("v%0d_fe_cleared", i), 32'(Frame_err), 32'd0);
      end
      if (vecs[i].drain) drain($sformatf("v%0d", i));
      #(BIT_NS);
    end

    // Short low pulse on an idle line is rejected at the start-bit centre.
    @(posedge Clk) #1 Rx = 1'b0;
    #(GLITCH_NS) Rx = 1'b1;
    #(2 * BIT_NS);
    @(negedge Clk);
    chk("glitch_level", 32'(Rx_level), 32'd0);
    chk("glitch_valid", 32'(Rx_valid), 32'd0);
    chk("glitch_frame_err", 32'(Frame_err), 32'd0);
    send_frame(8'h96, 1'b1);
    q.push_back(8'h96);
    repeat (4) @(negedge Clk);
    chk("post_glitch_level", 32'(Rx_level), 32'd1);
    chk("post_glitch_data", 32'(Rx_data), 32'h96);
    drain("glitch");

    // Fill past capacity: the 17th byte is dropped and flagged.
    for (int k = 0; k <= DEPTH; k++) begin
      send_frame(8'(k), 1'b1);
      if (k < DEPTH) q.push_back(8'(k));
    end
    repeat (4) @(negedge Clk);
    chk("ovr_level", 32'(Rx_level), 32'(DEPTH));
    chk("ovr_flag", 32'(Overrun_err), 32'd1);
    chk("ovr_frame_err", 32'(Frame_err), 32'd0);
    chk("ovr_head", 32'(Rx_data), 32'h00);
    pops_before = pops;
    drain("ovr");
    chk("ovr_pop_count", 32'(pops - pops_before), 32'(DEPTH));
    chk("ovr_flag_sticky", 32'(Overrun_err), 32'd1);
    err_clear();
    chk("ovr_flag_cleared", 32'(Overrun_err), 32'd0);
    #(BIT_NS);

    // Reset in the middle of a frame while a byte is buffered.
    send_frame(8'hC3, 1'b1);
    q.push_back(8'hC3);
    repeat (4) @(negedge Clk);
    chk("prerst_level", 32'(Rx_level), 32'd1);
    Rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      Rx = 1'(8'h77 >> i);
      #(BIT_NS);
    end
    Rx = 1'b1;
    #(BIT_NS / 2);
    Rst_n = 1'b0;
    q.delete();
    repeat (3) @(negedge Clk);
    chk("midrst_valid", 32'(Rx_valid), 32'd0);
    chk("midrst_level", 32'(Rx_level), 32'd0);
    chk("midrst_data", 32'(Rx_data), 32'd0);
    chk("midrst_frame_err", 32'(Frame_err), 32'd0);
    chk("midrst_overrun", 32'(Overrun_err), 32'd0);
    @(posedge Clk) #1 Rst_n = 1'b1;
    #(2 * BIT_NS);
    send_frame(8'h5A, 1'b1);
    q.push_back(8'h5A);
    repeat (4) @(negedge Clk);
    chk("postrst_level", 32'(Rx_level), 32'd1);
    chk("postrst_data", 32'(Rx_data), 32'h5A);
    chk("postrst_frame_err", 32'(Frame_err), 32'd0);
    drain("postrst");
    #(BIT_NS);

    // Back-to-back frames with the consumer always ready.
    @(posedge Clk) #1 Rx_ready = 1'b1;
    max_lvl = 0;
    track = 1'b1;
    pops_before = pops;
    q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    q.push_back(8'h22);
    send_frame(8'h22, 1'b1);
    q.push_back(8'h33);
    send_frame(8'h33, 1'b1);
    repeat (20) @(negedge Clk);
    track = 1'b0;
    chk("b2b_max_level", 32'(max_lvl), 32'd1);
    chk("b2b_pop_count", 32'(pops - pops_before), 32'd3);
    chk("b2b_queue", 32'(q.size()), 32'd0);
    chk("b2b_level", 32'(Rx_level), 32'd0);
    @(posedge Clk) #1 Rx_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
